// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the two-port memory arbiter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_AUX  = 1'b1;

   localparam int   PRI_RR    = 0;
   localparam int   PRI_FIXED = 1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// rtl/mem_arbiter_arb_rr2.sv - two-way grant select, round-robin or port 0 fixed priority
module arb_rr2
   import mem_arbiter_pkg::*;
#(
   parameter int PRIORITY = PRI_RR
) (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      grant_valid = |req;
      grant_idx   = PORT_CPU;
      case (req)
         2'b10:   grant_idx = PORT_AUX;
         // On a tie round-robin hands the grant to the port that did not win last.
         2'b11:   grant_idx = (PRIORITY == PRI_FIXED) ? PORT_CPU : ~last_grant;
         default: grant_idx = PORT_CPU;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises two req/ack masters onto one synchronous byte memory
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW       = 20,
   parameter int DW       = 8,
   parameter int LATENCY  = 1,
   parameter int PRIORITY = PRI_RR
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          p0_req,
   input  logic [AW-1:0] p0_address,
   input  logic [DW-1:0] p0_wdata,
   input  logic          p0_we,
   output logic          p0_ack,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_req,
   input  logic [AW-1:0] p1_address,
   input  logic [DW-1:0] p1_wdata,
   input  logic          p1_we,
   output logic          p1_ack,
   output logic [DW-1:0] p1_rdata,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_d,
   output logic          mem_we,
   input  logic [DW-1:0] mem_q,
   output logic          busy
);

   localparam logic [1:0] LAT = 2'(LATENCY);

   state_t     state;
   logic       last_grant;
   logic [1:0] wait_cnt;
   logic       grant_valid;
   logic       grant_idx;

   arb_rr2 #(
      .PRIORITY (PRIORITY)
   ) u_arb (
      .req         ({p1_req, p0_req}),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // last_grant doubles as the owner of the transaction in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_grant  <= PORT_AUX;
         wait_cnt    <= '0;
         mem_address <= '0;
         mem_d       <= '0;
         mem_we      <= 1'b0;
         p0_ack      <= 1'b0;
         p1_ack      <= 1'b0;
         p0_rdata    <= '0;
         p1_rdata    <= '0;
         busy        <= 1'b0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  last_grant  <= grant_idx;
                  mem_address <= (grant_idx == PORT_AUX) ? p1_address : p0_address;
                  mem_d       <= (grant_idx == PORT_AUX) ? p1_wdata   : p0_wdata;
                  mem_we      <= (grant_idx == PORT_AUX) ? p1_we      : p0_we;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               mem_we   <= 1'b0;
               wait_cnt <= LAT;
               if (mem_we) begin
                  p0_ack <= (last_grant == PORT_CPU);
                  p1_ack <= (last_grant == PORT_AUX);
                  state  <= ACK;
               end else begin
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == 2'd1) begin
                  if (last_grant == PORT_AUX) begin
                     p1_rdata <= mem_q;
                     p1_ack   <= 1'b1;
                  end else begin
                     p0_rdata <= mem_q;
                     p0_ack   <= 1'b1;
                  end
                  state <= ACK;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            ACK: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW = 20;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset_n    [2];
   logic          p0_req     [2];
   logic          p0_we      [2];
   logic          p1_req     [2];
   logic          p1_we      [2];
   logic [AW-1:0] p0_address [2];
   logic [AW-1:0] p1_address [2];
   logic [AW-1:0] mem_address[2];
   logic [DW-1:0] p0_wdata   [2];
   logic [DW-1:0] p1_wdata   [2];
   logic [DW-1:0] p0_rdata   [2];
   logic [DW-1:0] p1_rdata   [2];
   logic [DW-1:0] mem_d      [2];
   logic          p0_ack     [2];
   logic          p1_ack     [2];
   logic          mem_we     [2];
   logic          busy       [2];
   logic [DW-1:0] q_a;
   logic [DW-1:0] q_b1, q_b2, q_b3;

   logic [DW-1:0] mem_a [logic [AW-1:0]];
   logic [DW-1:0] mem_b [logic [AW-1:0]];

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(1), .PRIORITY(0)) u_rr (
      .clock(clock), .reset_n(reset_n[0]),
      .p0_req(p0_req[0]), .p0_address(p0_address[0]), .p0_wdata(p0_wdata[0]), .p0_we(p0_we[0]),
      .p0_ack(p0_ack[0]), .p0_rdata(p0_rdata[0]),
      .p1_req(p1_req[0]), .p1_address(p1_address[0]), .p1_wdata(p1_wdata[0]), .p1_we(p1_we[0]),
      .p1_ack(p1_ack[0]), .p1_rdata(p1_rdata[0]),
      .mem_address(mem_address[0]), .mem_d(mem_d[0]), .mem_we(mem_we[0]), .mem_q(q_a),
      .busy(busy[0])
   );

   mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(3), .PRIORITY(1)) u_fix (
      .clock(clock), .reset_n(reset_n[1]),
      .p0_req(p0_req[1]), .p0_address(p0_address[1]), .p0_wdata(p0_wdata[1]), .p0_we(p0_we[1]),
      .p0_ack(p0_ack[1]), .p0_rdata(p0_rdata[1]),
      .p1_req(p1_req[1]), .p1_address(p1_address[1]), .p1_wdata(p1_wdata[1]), .p1_we(p1_we[1]),
      .p1_ack(p1_ack[1]), .p1_rdata(p1_rdata[1]),
      .mem_address(mem_address[1]), .mem_d(mem_d[1]), .mem_we(mem_we[1]), .mem_q(q_b3),
      .busy(busy[1])
   );

   // one-cycle synchronous memory for u_rr
   always @(posedge clock) begin
      q_a <= mem_a.exists(mem_address[0]) ? mem_a[mem_address[0]] : '0;
      if (mem_we[0]) mem_a[mem_address[0]] = mem_d[0];
   end

   // three-cycle pipelined memory for u_fix
   always @(posedge clock) begin
      q_b1 <= mem_b.exists(mem_address[1]) ? mem_b[mem_address[1]] : '0;
      q_b2 <= q_b1;
      q_b3 <= q_b2;
      if (mem_we[1]) mem_b[mem_address[1]] = mem_d[1];
   end

   task automatic pulse_reset(input int d);
      @(negedge clock);
      reset_n[d] = 1'b0;
      p0_req[d]  = 1'b0;
      p1_req[d]  = 1'b0;
      @(negedge clock);
      reset_n[d] = 1'b1;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         reset_n[d] = 1'b0;
         p0_req[d] = 1'b0; p0_we[d] = 1'b0; p0_address[d] = '0; p0_wdata[d] = '0;
         p1_req[d] = 1'b0; p1_we[d] = 1'b0; p1_address[d] = '0; p1_wdata[d] = '0;
      end
      repeat (3) @(negedge clock);
      reset_n[0] = 1'b1;
      reset_n[1] = 1'b1;
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy[d], mem_we[d], p0_ack[d], p1_ack[d]} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl dut%0d: got %b want 0000", d, {busy[d], mem_we[d], p0_ack[d], p1_ack[d]});
         end
         checks++;
         if ({mem_address[d], mem_d[d]} !== '0) begin
            errors++; $display("FAIL reset_mem dut%0d: got addr %h d %h want 0", d, mem_address[d], mem_d[d]);
         end
         checks++;
         if ({p0_rdata[d], p1_rdata[d]} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata dut%0d: got %h want 0000", d, {p0_rdata[d], p1_rdata[d]});
         end
      end
   endtask

   task automatic test_read_lat1();
      logic saw_we;
      mem_a[20'h00123] = 8'h5A;
      saw_we = 1'b0;
      @(negedge clock);
      p0_address[0] = 20'h00123; p0_we[0] = 1'b0; p0_req[0] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         if (mem_we[0]) saw_we = 1'b1;
         if (k == 1) begin
            checks++;
            if (mem_address[0] !== 20'h00123) begin
               errors++; $display("FAIL rd1_addr: got %h want 00123", mem_address[0]);
            end
         end
         checks++;
         if (p0_ack[0] !== (k == 3)) begin
            errors++; $display("FAIL rd1_ack cycle %0d: got %b want %b", k, p0_ack[0], (k == 3));
         end
         checks++;
         if (busy[0] !== (k <= 3)) begin
            errors++; $display("FAIL rd1_busy cycle %0d: got %b want %b", k, busy[0], (k <= 3));
         end
         if (p0_ack[0] || k == 5) begin
            p0_req[0] = 1'b0;
            checks++;
            if (p0_rdata[0] !== 8'h5A) begin
               errors++; $display("FAIL rd1_rdata cycle %0d: got %h want 5a", k, p0_rdata[0]);
            end
         end
      end
      checks++;
      if (saw_we !== 1'b0) begin
         errors++; $display("FAIL rd1_we: got %b want 0", saw_we);
      end
   endtask

   task automatic test_write_then_read();
      int ack_k;
      @(negedge clock);
      p1_address[0] = 20'hA0010; p1_wdata[0] = 8'hC3; p1_we[0] = 1'b1; p1_req[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         checks++;
         if (mem_we[0] !== (k == 1)) begin
            errors++; $display("FAIL wr_we cycle %0d: got %b want %b", k, mem_we[0], (k == 1));
         end
         if (k == 1) begin
            checks++;
            if ({mem_address[0], mem_d[0]} !== {20'hA0010, 8'hC3}) begin
               errors++; $display("FAIL wr_bus: got %h/%h want a0010/c3", mem_address[0], mem_d[0]);
            end
         end
         checks++;
         if ({p0_ack[0], p1_ack[0]} !== {1'b0, (k == 2)}) begin
            errors++; $display("FAIL wr_ack cycle %0d: got %b want %b", k, {p0_ack[0], p1_ack[0]}, {1'b0, (k == 2)});
         end
         if (p1_ack[0]) begin p1_req[0] = 1'b0; p1_we[0] = 1'b0; end
      end
      p1_req[0] = 1'b0;
      checks++;
      if ({p0_rdata[0], p1_rdata[0]} !== {8'h5A, 8'h00}) begin
         errors++; $display("FAIL wr_rdata_untouched: got %h want 5a00", {p0_rdata[0], p1_rdata[0]});
      end
      @(negedge clock);
      p0_address[0] = 20'hA0010; p0_we[0] = 1'b0; p0_req[0] = 1'b1;
      ack_k = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (p0_ack[0] && ack_k < 0) begin
            ack_k = k;
            p0_req[0] = 1'b0;
            checks++;
            if (p0_rdata[0] !== 8'hC3) begin
               errors++; $display("FAIL raw_rdata: got %h want c3", p0_rdata[0]);
            end
         end
      end
      p0_req[0] = 1'b0;
      checks++;
      if (ack_k !== 3) begin
         errors++; $display("FAIL raw_ack_cycle: got %0d want 3", ack_k);
      end
   endtask

   task automatic test_round_robin();
      int order[6];
      int n;
      int dbl;
      logic drop0, drop1;
      pulse_reset(0);
      for (int i = 0; i < 6; i++) order[i] = -1;
      n = 0; dbl = 0; drop0 = 1'b0; drop1 = 1'b0;
      @(negedge clock);
      p0_address[0] = 20'h00010; p0_wdata[0] = 8'h11; p0_we[0] = 1'b1; p0_req[0] = 1'b1;
      p1_address[0] = 20'h00020; p1_wdata[0] = 8'h22; p1_we[0] = 1'b1; p1_req[0] = 1'b1;
      for (int k = 0; k < 60 && n < 6; k++) begin
         @(negedge clock);
         if (drop0) begin p0_req[0] = 1'b1; drop0 = 1'b0; end
         if (drop1) begin p1_req[0] = 1'b1; drop1 = 1'b0; end
         if (p0_ack[0] && p1_ack[0]) dbl++;
         if (p0_ack[0]) begin
            if (n < 6) order[n] = 0;
            n++; p0_req[0] = 1'b0; drop0 = 1'b1;
         end
         if (p1_ack[0]) begin
            if (n < 6) order[n] = 1;
            n++; p1_req[0] = 1'b0; drop1 = 1'b1;
         end
      end
      p0_req[0] = 1'b0; p1_req[0] = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if (n < 6) begin
         errors++; $display("FAIL rr_timeout: got %0d grants want 6", n);
      end
      checks++;
      if (dbl !== 0) begin
         errors++; $display("FAIL rr_double_ack: got %0d want 0", dbl);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (order[i] !== (i % 2)) begin
            errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      int first;
      @(negedge clock);
      p1_address[0] = 20'h00020; p1_we[0] = 1'b0; p1_req[0] = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++; $display("FAIL rst_busy_before: got %b want 1", busy[0]);
      end
      reset_n[0] = 1'b0;
      #1;
      checks++;
      if ({mem_we[0], busy[0], p1_ack[0]} !== 3'b000) begin
         errors++; $display("FAIL rst_async: got %b want 000", {mem_we[0], busy[0], p1_ack[0]});
      end
      p1_req[0] = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if ({p0_ack[0], p1_ack[0], busy[0], p1_rdata[0]} !== 11'd0) begin
         errors++; $display("FAIL rst_hold: got ack %b%b busy %b rdata %h want 0", p0_ack[0], p1_ack[0], busy[0], p1_rdata[0]);
      end
      reset_n[0] = 1'b1;
      @(negedge clock);
      p0_address[0] = 20'h00030; p0_wdata[0] = 8'h33; p0_we[0] = 1'b1; p0_req[0] = 1'b1;
      p1_address[0] = 20'h00040; p1_wdata[0] = 8'h44; p1_we[0] = 1'b1; p1_req[0] = 1'b1;
      first = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (p0_ack[0]) begin
            if (first < 0) first = 0;
            p0_req[0] = 1'b0;
         end
         if (p1_ack[0]) begin
            if (first < 0) first = 1;
            p1_req[0] = 1'b0;
         end
      end
      p0_req[0] = 1'b0; p1_req[0] = 1'b0;
      checks++;
      if (first !== 0) begin
         errors++; $display("FAIL rst_first_grant: got %0d want 0", first);
      end
   endtask

   task automatic test_fixed_priority();
      int n0, early1, last0, p1_k;
      logic drop0;
      pulse_reset(1);
      mem_b[20'h00777] = 8'h3C;
      n0 = 0; early1 = 0; last0 = -1; p1_k = -1; drop0 = 1'b0;
      @(negedge clock);
      p0_address[1] = 20'h00100; p0_wdata[1] = 8'h55; p0_we[1] = 1'b1; p0_req[1] = 1'b1;
      p1_address[1] = 20'h00777; p1_we[1] = 1'b0; p1_req[1] = 1'b1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clock);
         if (drop0 && n0 < 4) p0_req[1] = 1'b1;
         drop0 = 1'b0;
         if (p1_ack[1]) begin
            if (n0 < 4) early1++;
            p1_k = k;
            p1_req[1] = 1'b0;
            break;
         end
         if (p0_ack[1]) begin
            n0++; p0_req[1] = 1'b0; drop0 = 1'b1;
            if (n0 == 4) last0 = k;
         end
      end
      p0_req[1] = 1'b0; p1_req[1] = 1'b0;
      checks++;
      if (n0 !== 4) begin
         errors++; $display("FAIL fix_p0_grants: got %0d want 4", n0);
      end
      checks++;
      if (early1 !== 0) begin
         errors++; $display("FAIL fix_p1_early: got %0d want 0", early1);
      end
      checks++;
      if (p1_k < 0 || last0 < 0 || (p1_k - last0) > 6 || p1_k <= last0) begin
         errors++; $display("FAIL fix_p1_delay: got p1 at %0d p0 last at %0d want gap 1..6", p1_k, last0);
      end
      checks++;
      if (p1_rdata[1] !== 8'h3C) begin
         errors++; $display("FAIL fix_p1_rdata: got %h want 3c", p1_rdata[1]);
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_read_lat3();
      mem_b[20'hFE000] = 8'hEA;
      @(negedge clock);
      p0_address[1] = 20'hFE000; p0_we[1] = 1'b0; p0_req[1] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         if (k <= 5) begin
            checks++;
            if (mem_address[1] !== 20'hFE000) begin
               errors++; $display("FAIL rd3_addr cycle %0d: got %h want fe000", k, mem_address[1]);
            end
         end
         checks++;
         if (p0_ack[1] !== (k == 5)) begin
            errors++; $display("FAIL rd3_ack cycle %0d: got %b want %b", k, p0_ack[1], (k == 5));
         end
         if (p0_ack[1]) begin
            p0_req[1] = 1'b0;
            checks++;
            if (p0_rdata[1] !== 8'hEA) begin
               errors++; $display("FAIL rd3_rdata: got %h want ea", p0_rdata[1]);
            end
         end
      end
      p0_req[1] = 1'b0;
      checks++;
      if (p1_rdata[1] !== 8'h3C) begin
         errors++; $display("FAIL rd3_other_rdata: got %h want 3c", p1_rdata[1]);
      end
   endtask

   initial begin
      test_reset();
      test_read_lat1();
      test_write_then_read();
      test_round_robin();
      test_reset_mid_wait();
      test_fixed_priority();
      test_read_lat3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous byte memory between two bus masters: port 0 is the CPU and port 1 is a secondary master such as a DMA or SD loader.
- Sits between the masters and the memory router. The memory router's address decode and `we` gating are unchanged.
- Each master uses a req/ack handshake. The arbiter serialises accesses and issues exactly one memory cycle per grant.

Parameters:
- AW, 20, address width in bits.
- DW, 8, data width in bits.
- LATENCY, 1, memory read latency in cycles. Legal range is 1..3.
- PRIORITY, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 winning.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request.
- p0_address  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_we  in  1  port 0 write enable: 1 = write, 0 = read.
- p0_ack  out  1  one-cycle completion pulse for port 0.
- p0_rdata  out  DW  port 0 read data. Valid while p0_ack is high; holds its value afterwards.
- p1_req, p1_address, p1_wdata, p1_we, p1_ack, p1_rdata: identical to the port 0 signals, for port 1.
- mem_address  out  AW  memory address.
- mem_d  out  DW  memory write data.
- mem_we  out  1  memory write strobe.
- mem_q  in  DW  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset and clock: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset values: state = IDLE, all outputs 0, last_grant = 1, so port 0 wins the first tie.
- All outputs are registered.
- Handshake rules:
  - A master holds req, address, wdata and we stable from req rise until it samples ack.
  - The master drops req at the clock edge that samples ack high.
  - If req is still high in the cycle after ack, it is a new transaction.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Stays in IDLE if no req is high.
  - Otherwise selects a grant. With one requester, that requester wins.
  - With both requesting and PRIORITY=0, the port opposite last_grant wins. With PRIORITY=1, port 0 wins.
  - On that edge: loads mem_address/mem_d from the winner, sets mem_we = winner's we, updates last_grant, goes to ISSUE.
- ISSUE (exactly one cycle):
  - mem_we is high only in this state, and only for writes.
  - Next state is ACK for a write, WAIT for a read; the WAIT counter is loaded with LATENCY.
- WAIT:
  - mem_we = 0; the counter decrements each cycle.
  - On the edge where the counter reaches 1, mem_q is captured into the granted port's rdata and the FSM goes to ACK.
- ACK (one cycle):
  - Granted port's ack = 1; next state is IDLE.
  - ack is never high on both ports at once.
- Latency, measured from req high with the arbiter in IDLE (cycle 0):
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+LATENCY.
  - Minimum turnaround between back-to-back grants: write 3 cycles, read 3+LATENCY cycles.
- mem_address and mem_d hold their last value outside ISSUE. mem_we = 0 outside ISSUE.
- rdata of the non-granted port is never modified.
- Boundary conditions:
  - A request arriving while busy waits. It is evaluated at the next IDLE.
  - Round-robin guarantees no starvation. PRIORITY=1 may starve port 1 by design.
  - Both ports accessing the same address are serialised in grant order. A read after a write returns the written data.
  - A write never updates rdata.
  - Reset mid-operation aborts the transaction: no ack, mem_we = 0 immediately, state = IDLE, last_grant = 1.
  - A requester dropping req before ack is a protocol violation. The arbiter still completes and pulses ack.

Decomposition:
- Shared package: state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, ACK = 3), PORT_CPU = 0, PORT_AUX = 1, PRI_RR = 0, PRI_FIXED = 1.
- One sub-module, arb_rr2: combinational two-way grant selection from req[1:0], last_grant and PRIORITY. It outputs grant_valid and grant_idx.

Test Plan:
1. Port 0 read, LATENCY=1, memory at 0x00123 preloaded with 0x5A, req in cycle 0 -> mem_we never high, mem_address = 0x00123 in cycle 1, p0_ack only in cycle 3, p0_rdata = 0x5A, busy high in cycles 1–3.
2. Port 1 writes 0xC3 to 0xA0010 -> mem_we high exactly in cycle 1 with mem_d = 0xC3, p1_ack in cycle 2. A following port 0 read of 0xA0010 returns 0xC3.
3. PRIORITY=0, both ports requesting continuously (each re-raises req after ack), 6 grants -> grant order 0,1,0,1,0,1 and never two acks in the same cycle.
4. PRIORITY=1, both ports requesting continuously -> only port 0 is acked. When port 0 stops requesting, port 1 is acked within 3+LATENCY cycles.
5. reset_n pulsed low during WAIT of a port 1 read -> no ack, mem_we = 0, busy = 0. After release, a simultaneous request is granted to port 0 first.
6. LATENCY=3, port 0 read of 0xFE000 holding 0xEA -> p0_ack in cycle 5, p0_rdata = 0xEA, mem_address stable from cycle 1 until p0_ack.
